// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file port sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_pkg;

    localparam int NUM_WINDOWS = 4;
    localparam int WIN_W       = $clog2(NUM_WINDOWS);
    localparam int REG_W       = 5;
    localparam int DATA_W      = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // rf_rw encodings
    localparam logic RF_READ  = 1'b0;
    localparam logic RF_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ_A = 3'd1,
        READ_B = 3'd2,
        HOLD   = 3'd3,
        WRITE  = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_port_sequencer_if.sv
// Bundle of the operand-fetch, write-back and register-file signals.
// Latency: n/a (wiring only).
// Backpressure: n/a; slave = sequencer, master = control unit / RF side.
// Groups: req_* (fetch request), op_* (operands out), wb_* (write-back),
// rf_* (register-file port), busy (sequencer not idle).
interface regfile_port_sequencer_if;
    import regfile_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [REG_W-1:0]    req_rs1;
    logic [REG_W-1:0]    req_rs2;
    logic [WIN_W-1:0]    req_cwp;

    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                op_valid;
    logic                op_ack;

    logic                wb_valid;
    logic                wb_ready;
    logic [REG_W-1:0]    wb_rd;
    logic [WIN_W-1:0]    wb_cwp;
    logic [DATA_W-1:0]   wb_data;

    logic                rf_enable;
    logic                rf_rw;
    logic [WIN_W-1:0]    rf_window;
    logic [REG_W-1:0]    rf_r_num;
    logic [DATA_W-1:0]   rf_in;
    logic [DATA_W-1:0]   rf_out;

    logic                busy;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_cwp, op_ack,
               wb_valid, wb_rd, wb_cwp, wb_data, rf_out,
        output req_ready, op_a, op_b, op_valid, wb_ready,
               rf_enable, rf_rw, rf_window, rf_r_num, rf_in, busy
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_cwp, op_ack,
               wb_valid, wb_rd, wb_cwp, wb_data, rf_out,
        input  req_ready, op_a, op_b, op_valid, wb_ready,
               rf_enable, rf_rw, rf_window, rf_r_num, rf_in, busy
    );

endinterface

// File: rtl/regfile_port_sequencer.sv
// Sequences operand fetches (two RF reads) and write-backs onto one RF port.
// Latency: fetch accept -> op_valid 3 cycles; write-back accept -> RF write edge 1 cycle.
// Backpressure: req_ready/wb_ready only in IDLE (write-back wins); operands held until op_ack.
// Ports: Clk, Clr (async active-high reset), bus (slave modport: req_*, op_*, wb_*, rf_*, busy).
module regfile_port_sequencer
    import regfile_pkg::*;
(
    input  logic                       Clk,
    input  logic                       Clr,
    regfile_port_sequencer_if.slave    bus
);

    state_t              state;
    state_t              state_nxt;

    logic                take_req;
    logic                take_wb;
    logic                rf_enable_c;
    logic                rf_rw_c;
    logic                op_valid_c;

    logic [REG_W-1:0]    r_num_q;
    logic [REG_W-1:0]    rs2_q;
    logic [WIN_W-1:0]    window_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   op_a_q;
    logic [DATA_W-1:0]   op_b_q;
    logic [DATA_W-1:0]   rd_val;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next state and combinational outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        take_req    = 1'b0;
        take_wb     = 1'b0;
        rf_enable_c = 1'b0;
        rf_rw_c     = RF_READ;
        op_valid_c  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.wb_valid) begin
                    take_wb   = 1'b1;
                    state_nxt = WRITE;
                end else if (bus.req_valid) begin
                    take_req  = 1'b1;
                    state_nxt = READ_A;
                end
            end
            READ_A: begin
                rf_enable_c = 1'b1;
                state_nxt   = READ_B;
            end
            READ_B: begin
                rf_enable_c = 1'b1;
                state_nxt   = HOLD;
            end
            HOLD: begin
                op_valid_c = 1'b1;
                if (bus.op_ack) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                rf_rw_c = RF_WRITE;
                // Writes to r0 are acknowledged but never reach the RF.
                rf_enable_c = (r_num_q != REG_ZERO);
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // r0 always reads as zero; the RF cycle still happens.
    assign rd_val = (r_num_q == REG_ZERO) ? '0 : bus.rf_out;

    // ---------------------------------------------------------------
    // Datapath. r_num_q/window_q drive the RF address directly, so they
    // are loaded one edge ahead of the state that uses them and simply
    // hold in IDLE and HOLD.
    // ---------------------------------------------------------------
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_num_q  <= '0;
            rs2_q    <= '0;
            window_q <= '0;
            wdata_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
        end else begin
            if (take_wb) begin
                r_num_q  <= bus.wb_rd;
                window_q <= bus.wb_cwp;
                wdata_q  <= bus.wb_data;
            end
            if (take_req) begin
                r_num_q  <= bus.req_rs1;
                rs2_q    <= bus.req_rs2;
                window_q <= bus.req_cwp;
            end
            if (state == READ_A) begin
                op_a_q  <= rd_val;
                r_num_q <= rs2_q;
            end
            if (state == READ_B) begin
                op_b_q <= rd_val;
            end
        end
    end

    assign bus.req_ready = take_req;
    assign bus.wb_ready  = take_wb;
    assign bus.op_valid  = op_valid_c;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.rf_enable = rf_enable_c;
    assign bus.rf_rw     = rf_rw_c;
    assign bus.rf_window = window_q;
    assign bus.rf_r_num  = r_num_q;
    assign bus.rf_in     = wdata_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench for regfile_port_sequencer with a small windowed RF model.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_port_sequencer;

    logic Clk;
    logic Clr;
    logic force_ff;

    int err_cnt;
    int chk_cnt;

    regfile_port_sequencer_if bus ();

    regfile_port_sequencer dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register-file model: 4 windows x 32 registers, combinational read.
    logic [31:0] mem [4][32];

    always @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int w = 0; w < 4; w++) begin
                for (int r = 0; r < 32; r++) begin
                    mem[w][r] <= '0;
                end
            end
        end else if (bus.rf_enable && bus.rf_rw) begin
            mem[bus.rf_window][bus.rf_r_num] <= bus.rf_in;
        end
    end

    assign bus.rf_out = force_ff ? 32'hFFFF_FFFF : mem[bus.rf_window][bus.rf_r_num];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_write(input logic [4:0] rd, input logic [1:0] cwp, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_cwp   = cwp;
        bus.wb_data  = data;
        #1;
        check("wb_ready", bus.wb_ready, 1);
        check("wb_req_ready", bus.req_ready, 0);
        @(posedge Clk); @(negedge Clk);
        bus.wb_valid = 1'b0;
        #1;
        check("wr_rf_rw", bus.rf_rw, 1);
        check("wr_rf_enable", bus.rf_enable, (rd != 5'd0) ? 1 : 0);
        check("wr_rf_r_num", bus.rf_r_num, rd);
        check("wr_rf_window", bus.rf_window, cwp);
        check("wr_rf_in", bus.rf_in, data);
        check("wr_busy", bus.busy, 1);
        @(posedge Clk); @(negedge Clk);
        #1;
        check("wr_done_busy", bus.busy, 0);
        check("wr_idle_rf_enable", bus.rf_enable, 0);
        check("wr_idle_rf_rw", bus.rf_rw, 0);
        check("wr_idle_r_num_hold", bus.rf_r_num, rd);
    endtask

    task automatic do_fetch(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] cwp,
                            input logic [31:0] exp_a, input logic [31:0] exp_b, input int hold);
        bus.req_valid = 1'b1;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_cwp   = cwp;
        #1;
        check("rd_req_ready", bus.req_ready, 1);
        check("rd_wb_ready", bus.wb_ready, 0);
        @(posedge Clk); @(negedge Clk);
        bus.req_valid = 1'b0;
        #1;
        check("ra_rf_enable", bus.rf_enable, 1);
        check("ra_rf_rw", bus.rf_rw, 0);
        check("ra_rf_r_num", bus.rf_r_num, rs1);
        check("ra_rf_window", bus.rf_window, cwp);
        check("ra_op_valid", bus.op_valid, 0);
        @(posedge Clk); @(negedge Clk);
        #1;
        check("rb_rf_r_num", bus.rf_r_num, rs2);
        check("rb_rf_window", bus.rf_window, cwp);
        check("rb_op_a", bus.op_a, exp_a);
        check("rb_op_valid", bus.op_valid, 0);
        @(posedge Clk); @(negedge Clk);
        #1;
        check("hold_op_valid", bus.op_valid, 1);
        check("hold_op_a", bus.op_a, exp_a);
        check("hold_op_b", bus.op_b, exp_b);
        check("hold_rf_enable", bus.rf_enable, 0);
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.wb_valid  = 1'b1;
            #1;
            check("hold_req_ready", bus.req_ready, 0);
            check("hold_wb_ready", bus.wb_ready, 0);
            @(posedge Clk); @(negedge Clk);
            #1;
            check("hold_stay_valid", bus.op_valid, 1);
            check("hold_stable_a", bus.op_a, exp_a);
            check("hold_stable_b", bus.op_b, exp_b);
        end
        bus.req_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.op_ack    = 1'b1;
        @(posedge Clk); @(negedge Clk);
        bus.op_ack = 1'b0;
        #1;
        check("ack_busy", bus.busy, 0);
        check("ack_op_valid", bus.op_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        err_cnt       = 0;
        chk_cnt       = 0;
        Clr           = 1'b1;
        force_ff      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_cwp   = '0;
        bus.op_ack    = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_cwp    = '0;
        bus.wb_data   = '0;

        // Reset state
        repeat (2) @(negedge Clk);
        check("rst_busy", bus.busy, 0);
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_op_a", bus.op_a, 0);
        check("rst_rf_enable", bus.rf_enable, 0);
        check("rst_rf_r_num", bus.rf_r_num, 0);
        check("rst_rf_in", bus.rf_in, 0);
        Clr = 1'b0;
        #1;

        // Reset in the middle of READ_B
        force_ff      = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd5;
        bus.req_rs2   = 5'd6;
        bus.req_cwp   = 2'd3;
        @(posedge Clk); @(negedge Clk);
        bus.req_valid = 1'b0;
        @(posedge Clk); @(negedge Clk);
        #1;
        check("mid_op_a", bus.op_a, 32'hFFFF_FFFF);
        check("mid_busy", bus.busy, 1);
        check("mid_rf_enable", bus.rf_enable, 1);
        #1 Clr = 1'b1;
        #1;
        check("clr_op_valid", bus.op_valid, 0);
        check("clr_busy", bus.busy, 0);
        check("clr_rf_enable", bus.rf_enable, 0);
        check("clr_op_a", bus.op_a, 0);
        check("clr_rf_r_num", bus.rf_r_num, 0);
        check("clr_rf_window", bus.rf_window, 0);
        Clr      = 1'b0;
        force_ff = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            #1;
            check("post_clr_op_valid", bus.op_valid, 0);
            check("post_clr_busy", bus.busy, 0);
        end

        // Write then read back
        do_write(5'd9, 2'd1, 32'hDEAD_BEEF);
        do_fetch(5'd9, 5'd9, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);

        // r0: write suppressed, read forced to zero
        do_write(5'd0, 2'd1, 32'h0000_1234);
        force_ff = 1'b1;
        do_fetch(5'd0, 5'd9, 2'd1, 32'h0, 32'hFFFF_FFFF, 0);
        force_ff = 1'b0;

        // Write-back wins over a simultaneous fetch
        bus.wb_valid  = 1'b1;
        bus.wb_rd     = 5'd3;
        bus.wb_cwp    = 2'd0;
        bus.wb_data   = 32'h0000_0055;
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd3;
        bus.req_rs2   = 5'd0;
        bus.req_cwp   = 2'd0;
        #1;
        check("pri_wb_ready", bus.wb_ready, 1);
        check("pri_req_ready", bus.req_ready, 0);
        @(posedge Clk); @(negedge Clk);
        bus.wb_valid = 1'b0;
        #1;
        check("pri_write_req_ready", bus.req_ready, 0);
        check("pri_write_rf_rw", bus.rf_rw, 1);
        @(posedge Clk); @(negedge Clk);
        do_fetch(5'd3, 5'd0, 2'd0, 32'h0000_0055, 32'h0, 0);

        // Operands held while op_ack is withheld
        do_fetch(5'd9, 5'd3, 2'd1, 32'hDEAD_BEEF, 32'h0, 5);

        // Window selection
        do_write(5'd10, 2'd0, 32'h0000_0077);
        do_write(5'd10, 2'd2, 32'h0000_00A5);
        do_fetch(5'd10, 5'd10, 2'd2, 32'h0000_00A5, 32'h0000_00A5, 0);
        do_fetch(5'd10, 5'd10, 2'd0, 32'h0000_0077, 32'h0000_0077, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
